// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew
// Realigns the skewed partial-sum bus of a weight-stationary systolic array
// into whole rows and buffers them in a small FIFO drained over valid/ready.
// The array cannot be stalled, so a row arriving at a full FIFO is dropped
// and a sticky overflow flag records the loss.
// Optional feature macro: OUTPUT_RELU_EN (clamps negative lanes to zero on
// the FIFO write path).

module systolic_output_deskew #(
    parameter  int ARR_WIDTH  = 8,
    parameter  int WORD_WIDTH = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int PS_W       = 4 * WORD_WIDTH,
    localparam int BUS_W      = PS_W * ARR_WIDTH,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [BUS_W-1:0] ps_in_vec,
    input  logic             ps_in_valid,
    output logic [BUS_W-1:0] out_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    fifo_count,
    output logic             overflow,
    input  logic             ovf_clear
);

    logic [BUS_W-1:0] aligned_row;
    logic             aligned_valid;
    logic [BUS_W-1:0] wr_row;

    // Per-lane delay lines: lane c waits ARR_WIDTH-1-c cycles so every lane
    // of a row lands on the same edge as the last (undelayed) lane.
    for (genvar c = 0; c < ARR_WIDTH; c++) begin : g_lane
        localparam int D = ARR_WIDTH - 1 - c;
        if (D == 0) begin : g_pass
            assign aligned_row[c*PS_W +: PS_W] = ps_in_vec[c*PS_W +: PS_W];
        end else begin : g_dly
            logic [PS_W-1:0] pipe [D];

            // Shift lane c through its D-stage delay line
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < D; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= ps_in_vec[c*PS_W +: PS_W];
                    for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign aligned_row[c*PS_W +: PS_W] = pipe[D-1];
        end
    end

    // Row-valid tag follows lane 0 through the longest delay
    if (ARR_WIDTH > 1) begin : g_vpipe
        logic vpipe [ARR_WIDTH-1];

        // Delay ps_in_valid by ARR_WIDTH-1 cycles to mark fully aligned rows
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < ARR_WIDTH - 1; i++) vpipe[i] <= 1'b0;
            end else begin
                vpipe[0] <= ps_in_valid;
                for (int i = 1; i < ARR_WIDTH - 1; i++) vpipe[i] <= vpipe[i-1];
            end
        end

        assign aligned_valid = vpipe[ARR_WIDTH-2];
    end else begin : g_vpass
        assign aligned_valid = ps_in_valid;
    end

`ifdef OUTPUT_RELU_EN
    // Clamp negative lanes to zero just before they enter the FIFO
    always_comb begin
        wr_row = aligned_row;
        for (int c = 0; c < ARR_WIDTH; c++) begin
            if (aligned_row[(c+1)*PS_W-1]) wr_row[c*PS_W +: PS_W] = '0;
        end
    end
`else
    assign wr_row = aligned_row;
`endif

    logic [BUS_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a row when the head leaves on the same edge
    assign push      = aligned_valid && (!full || pop);
    assign drop      = aligned_valid && full && !pop;
    assign out_row   = mem[rd_ptr];

    // Row storage; cleared on reset so the head reads zero while empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wr_row;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
        end
    end

    // Sticky overflow; a drop on the clearing edge keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (ovf_clear) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew (4 lanes, 32-bit lanes, 4-deep FIFO).
// Rows are injected with the array's skew: lane c of a row is driven c cycles
// after its ps_in_valid, so the bench keeps a short history of injected rows.

module tb_systolic_output_deskew;

    localparam int AW   = 4;
    localparam int WW   = 8;
    localparam int FD   = 4;
    localparam int PSW  = 4 * WW;
    localparam int BW   = PSW * AW;
    localparam int CW   = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [BW-1:0] ps_in_vec;
    logic          ps_in_valid;
    logic [BW-1:0] out_row;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          ovf_clear;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] hist_row [AW];
    logic          hist_v   [AW];

    systolic_output_deskew #(
        .ARR_WIDTH (AW),
        .WORD_WIDTH(WW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps_in_vec  (ps_in_vec),
        .ps_in_valid(ps_in_valid),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk_row(input logic [31:0] b);
        logic [BW-1:0] r;
        for (int c = 0; c < AW; c++) r[c*PSW +: PSW] = b + 32'(c);
        return r;
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        for (int k = 0; k < AW; k++) begin
            hist_row[k] = '0;
            hist_v[k]   = 1'b0;
        end
    endtask

    // One clock: inject (or not) a new row, drive the skewed lanes, set
    // out_ready, then return 1 time unit after the rising edge.
    task automatic cycle(input logic v, input logic [BW-1:0] row, input logic rdy);
        for (int k = AW - 1; k > 0; k--) begin
            hist_row[k] = hist_row[k-1];
            hist_v[k]   = hist_v[k-1];
        end
        hist_row[0] = row;
        hist_v[0]   = v;
        ps_in_valid = v;
        for (int c = 0; c < AW; c++)
            ps_in_vec[c*PSW +: PSW] = hist_v[c] ? hist_row[c][c*PSW +: PSW]
                                                : (32'hDEAD_0000 | 32'(c));
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    logic [BW-1:0] relu_row;
    logic [BW-1:0] relu_exp;

    initial begin
        reset_n     = 1'b0;
        ps_in_vec   = '0;
        ps_in_valid = 1'b0;
        out_ready   = 1'b0;
        ovf_clear   = 1'b0;
        clear_hist();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_out_valid", BW'(out_valid), '0);
        check("rst_count", BW'(fifo_count), '0);
        check("rst_overflow", BW'(overflow), '0);
        check("rst_out_row", out_row, '0);
        reset_n = 1'b1;

        // Skew / latency: row valid at edge t appears after edge t+3
        cycle(1'b1, mk_row(32'h10), 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("skew_early_valid", BW'(out_valid), '0);
        cycle(1'b0, '0, 1'b0);
        check("skew_valid", BW'(out_valid), BW'(1));
        check("skew_row", out_row, {32'h13, 32'h12, 32'h11, 32'h10});
        check("skew_count", BW'(fifo_count), BW'(1));
        cycle(1'b0, '0, 1'b0);
        check("skew_hold_row", out_row, {32'h13, 32'h12, 32'h11, 32'h10});
        cycle(1'b0, '0, 1'b1);
        check("skew_popped_valid", BW'(out_valid), '0);
        check("skew_popped_count", BW'(fifo_count), '0);

        // Streaming: 8 back-to-back rows with out_ready held high
        for (int i = 0; i < 12; i++) begin
            cycle(i < 8, mk_row(32'h100 + 32'h10 * 32'(i)), 1'b1);
            if (i >= 3 && i <= 10) begin
                check("stream_valid", BW'(out_valid), BW'(1));
                check("stream_row", out_row, mk_row(32'h100 + 32'h10 * 32'(i - 3)));
                check("stream_count", BW'(fifo_count), BW'(1));
            end
        end
        check("stream_end_valid", BW'(out_valid), '0);
        check("stream_overflow", BW'(overflow), '0);

        // Full / drop: five rows into a stalled 4-deep FIFO
        for (int i = 0; i < 8; i++) begin
            cycle(i < 5, mk_row(32'h200 + 32'h10 * 32'(i)), 1'b0);
            if (i == 6) begin
                check("full_count", BW'(fifo_count), BW'(4));
                check("full_no_ovf_yet", BW'(overflow), '0);
            end
        end
        check("drop_count", BW'(fifo_count), BW'(4));
        check("drop_overflow", BW'(overflow), BW'(1));
        for (int j = 0; j < 4; j++) begin
            check("drain_row", out_row, mk_row(32'h200 + 32'h10 * 32'(j)));
            cycle(1'b0, '0, 1'b1);
        end
        check("drain_empty", BW'(out_valid), '0);
        check("drain_ovf_sticky", BW'(overflow), BW'(1));
        ovf_clear = 1'b1;
        cycle(1'b0, '0, 1'b0);
        ovf_clear = 1'b0;
        check("ovf_cleared", BW'(overflow), '0);

        // Full + simultaneous pop: fifth row accepted, count holds at 4
        for (int i = 0; i < 8; i++) begin
            cycle(i < 5, mk_row(32'h300 + 32'h10 * 32'(i)), i == 7);
        end
        check("fullpop_count", BW'(fifo_count), BW'(4));
        check("fullpop_overflow", BW'(overflow), '0);
        for (int j = 1; j < 5; j++) begin
            check("fullpop_row", out_row, mk_row(32'h300 + 32'h10 * 32'(j)));
            cycle(1'b0, '0, 1'b1);
        end
        check("fullpop_empty", BW'(fifo_count), '0);

        // Clear and a new drop on the same edge: set wins
        for (int i = 0; i < 9; i++) begin
            ovf_clear = (i == 8);
            cycle(i < 6, mk_row(32'h400 + 32'h10 * 32'(i)), 1'b0);
        end
        ovf_clear = 1'b0;
        check("setwins_overflow", BW'(overflow), BW'(1));
        for (int j = 0; j < 4; j++) cycle(1'b0, '0, 1'b1);
        check("setwins_drained", BW'(fifo_count), '0);
        ovf_clear = 1'b1;
        cycle(1'b0, '0, 1'b0);
        ovf_clear = 1'b0;
        check("setwins_cleared", BW'(overflow), '0);

        // Reset mid-run: 2 rows buffered, 1 in flight
        for (int i = 0; i < 5; i++) begin
            cycle(i < 3, mk_row(32'h500 + 32'h10 * 32'(i)), 1'b0);
        end
        check("midrst_pre_count", BW'(fifo_count), BW'(2));
        reset_n = 1'b0;
        ps_in_valid = 1'b0;
        clear_hist();
        #1;
        check("midrst_valid", BW'(out_valid), '0);
        check("midrst_count", BW'(fifo_count), '0);
        check("midrst_overflow", BW'(overflow), '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, '0, 1'b0);
            check("midrst_nothing", BW'(out_valid), '0);
        end

        // Negative lanes: clamped only when the ReLU option is built in
        relu_row = mk_row(32'h20);
        relu_row[63:32]   = 32'hFFFF_FFF0;
        relu_row[127:96]  = 32'h8000_0000;
        relu_exp = relu_row;
`ifdef OUTPUT_RELU_EN
        relu_exp[63:32]  = 32'h0;
        relu_exp[127:96] = 32'h0;
`endif
        cycle(1'b1, relu_row, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        check("relu_valid", BW'(out_valid), BW'(1));
        check("relu_row", out_row, relu_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
